// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM duty-cycle update sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_seq_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DW      = 8;

    // Per-channel shadow-update tracking state
    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_WRITE   = 2'd1,
        CH_PENDING = 2'd2
    } ch_state_e;

    // Index width that never collapses to zero bits for a single entry
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_seq_arbiter.sv
// Single-grant arbiter: round-robin from a rotating pointer, or lowest-index-wins when PWM_SEQ_FIXED_PRIO_EN is defined.
// Latency: grant is combinational from i_elig; the pointer advances on the clock after a grant.
// Backpressure: none; a requester that is not eligible is simply not granted.
module pwm_seq_arbiter
    import pwm_seq_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int RW      = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_elig,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [RW-1:0]      o_grant_idx,
    output logic               o_grant_vld
);

`ifdef PWM_SEQ_FIXED_PRIO_EN

    // Scan from the top down so the lowest eligible index is the last writer
    always_comb begin
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        o_grant     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_elig[i]) begin
                o_grant_idx = RW'(i);
                o_grant_vld = 1'b1;
            end
        end
        if (o_grant_vld) o_grant[o_grant_idx] = 1'b1;
    end

`else

    logic [RW-1:0] r_ptr;
    logic [RW-1:0] w_cand;

    // Scan offsets from the pointer in reverse so the smallest offset wins
    always_comb begin
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        o_grant     = '0;
        w_cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = RW'((int'(r_ptr) + i) % NUM_REQ);
            if (i_elig[w_cand]) begin
                o_grant_idx = w_cand;
                o_grant_vld = 1'b1;
            end
        end
        if (o_grant_vld) o_grant[o_grant_idx] = 1'b1;
    end

    // Pointer moves just past the winner; holds when nothing is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_grant_vld) begin
            r_ptr <= (int'(o_grant_idx) == NUM_REQ - 1) ? '0 : o_grant_idx + 1'b1;
        end
    end

`endif

endmodule

// File: rtl/pwm_update_sequencer.sv
// Shares the PWM shadow-register write port among requesters and reports when each write is consumed by a frame reload.
// Latency: grant at T -> ch_update/ch_data at T+1; req_done the cycle after the first frame_start seen in PENDING.
// Backpressure: req_ready is withheld while the target channel is busy or the requester already has an update in flight.
// Optional build macro: PWM_SEQ_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module pwm_update_sequencer
    import pwm_seq_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int DW      = DEF_DW,
    localparam int CHW     = clog2_min1(NUM_CH),
    localparam int RW      = clog2_min1(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*CHW-1:0] req_ch,
    input  logic [NUM_REQ*DW-1:0]  req_duty,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     req_done,
    input  logic [NUM_CH-1:0]      ch_frame_start,
    output logic [NUM_CH-1:0]      ch_update,
    output logic [DW-1:0]          ch_data,
    output logic                   busy
);

    ch_state_e         r_state [NUM_CH];
    ch_state_e         w_state_nxt [NUM_CH];
    logic [RW-1:0]     r_owner [NUM_CH];
    logic [NUM_CH-1:0] r_ch_update;
    logic [DW-1:0]     r_ch_data;
    logic [NUM_REQ-1:0] r_req_done;

    logic [NUM_REQ-1:0] w_blocked;
    logic [NUM_REQ-1:0] w_tgt_idle;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [RW-1:0]      w_gnt_idx;
    logic               w_gnt_vld;
    logic [CHW-1:0]     w_gnt_ch;
    logic [DW-1:0]      w_gnt_duty;
    logic [NUM_CH-1:0]  w_upd_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic               w_busy;

    // Eligibility: valid, in-range idle target, and no update already in flight for this requester
    always_comb begin
        w_blocked  = '0;
        w_tgt_idle = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (r_state[c] != CH_IDLE && r_owner[c] == RW'(r)) w_blocked[r] = 1'b1;
                if (req_ch[r*CHW +: CHW] == CHW'(c) && r_state[c] == CH_IDLE) w_tgt_idle[r] = 1'b1;
            end
        end
        w_elig = req_valid & w_tgt_idle & ~w_blocked & {NUM_REQ{~rst}};
    end

    pwm_seq_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_elig      (w_elig),
        .o_grant     (w_grant),
        .o_grant_idx (w_gnt_idx),
        .o_grant_vld (w_gnt_vld)
    );

    // Mux the winner's channel and duty onto the write path
    always_comb begin
        w_gnt_ch   = '0;
        w_gnt_duty = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_grant[r]) begin
                w_gnt_ch   = req_ch[r*CHW +: CHW];
                w_gnt_duty = req_duty[r*DW +: DW];
            end
        end
    end

    // Channel FSM next state, update strobe decode and commit pulses
    always_comb begin
        w_upd_nxt  = '0;
        w_done_nxt = '0;
        w_busy     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            if (r_state[c] != CH_IDLE) w_busy = 1'b1;
            case (r_state[c])
                CH_IDLE: begin
                    if (w_gnt_vld && w_gnt_ch == CHW'(c)) begin
                        w_state_nxt[c] = CH_WRITE;
                        w_upd_nxt[c]   = 1'b1;
                    end
                end
                // A frame_start coincident with the strobe reloaded the old shadow, so it is ignored here
                CH_WRITE: w_state_nxt[c] = CH_PENDING;
                CH_PENDING: begin
                    if (ch_frame_start[c]) begin
                        w_state_nxt[c]          = CH_IDLE;
                        w_done_nxt[r_owner[c]] = 1'b1;
                    end
                end
                default: w_state_nxt[c] = CH_IDLE;
            endcase
        end
    end

    // State, owner and output registers; reset drops all in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= CH_IDLE;
                r_owner[c] <= '0;
            end
            r_ch_update <= '0;
            r_ch_data   <= '0;
            r_req_done  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                if (w_upd_nxt[c]) r_owner[c] <= w_gnt_idx;
            end
            r_ch_update <= w_upd_nxt;
            r_req_done  <= w_done_nxt;
            if (w_gnt_vld) r_ch_data <= w_gnt_duty;
        end
    end

    assign req_ready = w_grant;
    assign req_done  = r_req_done;
    assign ch_update = r_ch_update;
    assign ch_data   = r_ch_data;
    assign busy      = w_busy;

endmodule

// File: tb/tb_pwm_update_sequencer.sv
module tb_pwm_update_sequencer;

    import pwm_seq_pkg::*;

`ifdef PWM_SEQ_FIXED_PRIO_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_ch;
    logic [31:0] req_duty;
    logic [3:0]  fs;
    logic [3:0]  req_ready, req_done, ch_update;
    logic [7:0]  ch_data;
    logic        busy;
    logic [3:0]  rdy3, done3;
    logic [2:0]  upd3;
    logic [7:0]  data3;
    logic        busy3;

    pwm_update_sequencer #(.NUM_REQ(4), .NUM_CH(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ch(req_ch), .req_duty(req_duty),
        .req_ready(req_ready), .req_done(req_done), .ch_frame_start(fs),
        .ch_update(ch_update), .ch_data(ch_data), .busy(busy)
    );

    pwm_update_sequencer #(.NUM_REQ(4), .NUM_CH(3), .DW(8)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ch(req_ch), .req_duty(req_duty),
        .req_ready(rdy3), .req_done(done3), .ch_frame_start(fs[2:0]),
        .ch_update(upd3), .ch_data(data3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [7:0]  ch;
        logic [31:0] duty;
        logic [3:0]  fs;
        logic [3:0]  rdy;
        logic [3:0]  upd;
        logic [7:0]  dat;
        logic [3:0]  done;
        logic        busy;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
            n_miss++;
        end
    endtask

    initial begin
        logic [7:0] d27;
        d27 = FIX ? 8'hB0 : 8'hB2;
        // reset, then r0/r1/r3 contend for ch0/ch1/ch3
        tbl[0]  = '{1'b1, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'hB, 8'hC4, 32'hA300A1A0,  4'h0, 4'h1, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 4'hB, 8'hC4, 32'hA300A1A0,  4'h0, 4'h2, 4'h1, 8'hA0, 4'h0, 1'b1};
        tbl[3]  = '{1'b0, 4'hB, 8'hC4, 32'hA300A1A0,  4'h0, 4'h8, 4'h2, 8'hA1, 4'h0, 1'b1};
        tbl[4]  = '{1'b0, 4'hB, 8'hC4, 32'hA300A1A0,  4'h0, 4'h0, 4'h8, 8'hA3, 4'h0, 1'b1};
        tbl[5]  = '{1'b0, 4'hB, 8'hC4, 32'hA300A1A0,  4'hB, 4'h0, 4'h0, 8'hA3, 4'h0, 1'b1};
        tbl[6]  = '{1'b0, 4'hB, 8'hC4, 32'hA300A1A0,  4'h0, 4'h1, 4'h0, 8'hA3, 4'hB, 1'b0};
        // reset right after a fresh grant: outputs clear at once
        tbl[7]  = '{1'b1, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0};
        // single write r1 -> ch2, duty 0x40, frame at T+5
        tbl[8]  = '{1'b0, 4'h2, 8'h08, 32'h00004000,  4'h0, 4'h2, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h4, 8'h40, 4'h0, 1'b1};
        tbl[10] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h40, 4'h0, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h40, 4'h0, 1'b1};
        tbl[12] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h40, 4'h0, 1'b1};
        tbl[13] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h4, 4'h0, 4'h0, 8'h40, 4'h0, 1'b1};
        tbl[14] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h40, 4'h2, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h40, 4'h0, 1'b0};
        // frame_start coincident with the strobe does not commit
        tbl[16] = '{1'b0, 4'h1, 8'h00, 32'h00000011,  4'h0, 4'h1, 4'h0, 8'h40, 4'h0, 1'b0};
        tbl[17] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h1, 4'h0, 4'h1, 8'h11, 4'h0, 1'b1};
        tbl[18] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h11, 4'h0, 1'b1};
        tbl[19] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h1, 4'h0, 4'h0, 8'h11, 4'h0, 1'b1};
        tbl[20] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h11, 4'h1, 1'b0};
        // r0 and r2 collide on ch1
        tbl[21] = '{1'b1, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[22] = '{1'b0, 4'h5, 8'h11, 32'h00B200B0,  4'h0, 4'h1, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[23] = '{1'b0, 4'h5, 8'h11, 32'h00B200B0,  4'h0, 4'h0, 4'h2, 8'hB0, 4'h0, 1'b1};
        tbl[24] = '{1'b0, 4'h5, 8'h11, 32'h00B200B0,  4'h0, 4'h0, 4'h0, 8'hB0, 4'h0, 1'b1};
        tbl[25] = '{1'b0, 4'h5, 8'h11, 32'h00B200B0,  4'h2, 4'h0, 4'h0, 8'hB0, 4'h0, 1'b1};
        tbl[26] = '{1'b0, 4'h5, 8'h11, 32'h00B200B0,  4'h0, FIX ? 4'h1 : 4'h4, 4'h0, 8'hB0, 4'h1, 1'b0};
        tbl[27] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h2, d27,   4'h0, 1'b1};
        tbl[28] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, d27,   4'h0, 1'b1};
        // reset with ch1 pending: later frame_start produces no done
        tbl[29] = '{1'b1, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[30] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h2, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[31] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0};
        // r2 gets one write in flight, then is blocked from a second channel
        tbl[32] = '{1'b0, 4'h4, 8'h10, 32'h00C20000,  4'h0, 4'h4, 4'h0, 8'h00, 4'h0, 1'b0};
        tbl[33] = '{1'b0, 4'h0, 8'h00, 32'h0,         4'h0, 4'h0, 4'h2, 8'hC2, 4'h0, 1'b1};
        tbl[34] = '{1'b0, 4'h4, 8'h30, 32'h0,         4'h0, 4'h0, 4'h0, 8'hC2, 4'h0, 1'b1};
        tbl[35] = '{1'b0, 4'h4, 8'h30, 32'h0,         4'h0, 4'h0, 4'h0, 8'hC2, 4'h0, 1'b1};

        rst = 1'b1; req_valid = '0; req_ch = '0; req_duty = '0; fs = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            req_valid = tbl[i].vld;
            req_ch    = tbl[i].ch;
            req_duty  = tbl[i].duty;
            fs        = tbl[i].fs;
            #1;
            n_vec++;
            chk("req_ready", i, 32'(req_ready), 32'(tbl[i].rdy));
            chk("ch_update", i, 32'(ch_update), 32'(tbl[i].upd));
            chk("ch_data",   i, 32'(ch_data),   32'(tbl[i].dat));
            chk("req_done",  i, 32'(req_done),  32'(tbl[i].done));
            chk("busy",      i, 32'(busy),      32'(tbl[i].busy));
        end

        // three-channel instance: r0 asks for ch3 (out of range), r1 for ch2
        @(negedge clk);
        rst = 1'b1; req_valid = '0; fs = '0;
        #1;
        n_vec++;
        chk("oor_reset_upd", 100, 32'(upd3), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst       = 1'b0;
            req_valid = 4'h3;
            req_ch    = 8'h0B;
            req_duty  = 32'h00005500;
            #1;
            n_vec++;
            chk("oor_ready",  101 + k, 32'(rdy3), (k == 0) ? 32'h2 : 32'h0);
            chk("oor_update", 101 + k, 32'(upd3), (k == 1) ? 32'h4 : 32'h0);
            if (k >= 1) chk("oor_data", 101 + k, 32'(data3), 32'h55);
        end

        @(negedge clk);
        req_valid = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
